// File: rtl/spi_master_tx_pkg.sv
// spi_master_tx_pkg: shared build macros and the one-hot state encoding.
// Optional feature macro: SPI_MASTER_MISO_CAPTURE_EN (miso capture into rx_data).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CPOL
`define CPOL 0
`endif
`ifndef CPHA
`define CPHA 0
`endif
`ifndef SPI_CLK_DIV
`define SPI_CLK_DIV 4
`endif

package spi_master_tx_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LEAD   = 5'b00010,
        XFER   = 5'b00100,
        TRAIL  = 5'b01000,
        FINISH = 5'b10000
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: clk divider, sclk edge counter and registered sclk.
// Optional feature macro SPI_MASTER_MISO_CAPTURE_EN does not affect this block.
module spi_sclk_gen
    import spi_master_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   CLK_DIV    = 4,
    parameter logic CPOL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic xfer,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge,
    output logic sclk
);

    localparam int NEDGE = 2 * DATA_WIDTH;
    localparam int DW    = cnt_w(CLK_DIV);
    localparam int EW    = cnt_w(NEDGE);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_MAX = EW'(NEDGE - 1);

    logic [DW-1:0] div_cnt;
    logic [EW-1:0] edge_cnt;
    logic          xtick;

    assign tick       = en && (div_cnt == DIV_MAX);
    assign xtick      = tick && xfer;
    assign lead_edge  = xtick && !edge_cnt[0];
    assign trail_edge = xtick && edge_cnt[0];
    assign last_edge  = xtick && (edge_cnt == EDGE_MAX);

    // Every state change lands on a tick, so wrapping on tick restarts the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!xfer || last_edge) begin
            edge_cnt <= '0;
        end else if (xtick) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk <= CPOL;
        end else if (!xfer) begin
            sclk <= CPOL;
        end else if (xtick) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI master transmitter, LSB first, CPOL/CPHA selectable.
// Optional feature macro SPI_MASTER_MISO_CAPTURE_EN adds miso and rx_data.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CPOL
`define CPOL 0
`endif
`ifndef CPHA
`define CPHA 0
`endif
`ifndef SPI_CLK_DIV
`define SPI_CLK_DIV 4
`endif

module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int CLK_DIV    = `SPI_CLK_DIV,
    parameter int CPOL       = `CPOL,
    parameter int CPHA       = `CPHA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_i,
`ifdef SPI_MASTER_MISO_CAPTURE_EN
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
`endif
    output logic                  busy,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  mosi,
    output logic                  tx_finish
);

    localparam logic POL = CPOL[0];
    localparam logic PHA = CPHA[0];

    state_t state;
    state_t state_d;

    logic                  tick;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  last_edge;
    logic                  en;
    logic                  xfer;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shreg;

    assign en     = (state == LEAD) || (state == XFER) || (state == TRAIL);
    assign xfer   = (state == XFER);
    assign accept = start && ((state == IDLE) || (state == FINISH));

    spi_sclk_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV),
        .CPOL       (POL)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .xfer       (xfer),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge),
        .sclk       (sclk)
    );

    // FINISH chains straight into LEAD so back-to-back frames keep a 1-cycle ss_n gap.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = LEAD;
            LEAD:    if (tick) state_d = XFER;
            XFER:    if (last_edge) state_d = TRAIL;
            TRAIL:   if (tick) state_d = FINISH;
            FINISH:  state_d = start ? LEAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ss_n      <= 1'b1;
            tx_finish <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= (state_d != IDLE);
            ss_n      <= (state_d == IDLE) || (state_d == FINISH);
            tx_finish <= (state_d == FINISH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            mosi  <= 1'b0;
        end else if (accept) begin
            shreg <= data_i;
            mosi  <= PHA ? 1'b0 : data_i[0];
        end else if ((state_d == FINISH) || (state_d == IDLE)) begin
            mosi  <= 1'b0;
        end else if (PHA) begin
            if (lead_edge) begin
                mosi  <= shreg[0];
                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
        end else if (trail_edge && !last_edge) begin
            mosi  <= shreg[1];
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
        end
    end

`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  samp;

    assign samp = PHA ? trail_edge : lead_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            if (accept) begin
                rx_sh <= '0;
            end else if (samp) begin
                rx_sh <= {miso, rx_sh[DATA_WIDTH-1:1]};
            end
            if (state_d == FINISH) begin
                rx_data <= rx_sh;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: mode 0 and mode 3 masters driven in lockstep,
// each watched by a slave-side model of the serial link.
module tb_spi_master_tx;

    localparam bit CPHA_M [2] = '{1'b0, 1'b1};

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] data_i = 8'h00;

    logic busy_w [2];
    logic sclk_w [2];
    logic ss_w   [2];
    logic mosi_w [2];
    logic fin_w  [2];
`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [7:0] rx_w [2];
`endif

    always #5 clk = ~clk;

    spi_master_tx #(
        .DATA_WIDTH (8),
        .CLK_DIV    (4),
        .CPOL       (0),
        .CPHA       (0)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_i    (data_i),
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        .miso      (mosi_w[0]),
        .rx_data   (rx_w[0]),
`endif
        .busy      (busy_w[0]),
        .sclk      (sclk_w[0]),
        .ss_n      (ss_w[0]),
        .mosi      (mosi_w[0]),
        .tx_finish (fin_w[0])
    );

    spi_master_tx #(
        .DATA_WIDTH (8),
        .CLK_DIV    (4),
        .CPOL       (1),
        .CPHA       (1)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_i    (data_i),
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        .miso      (mosi_w[1]),
        .rx_data   (rx_w[1]),
`endif
        .busy      (busy_w[1]),
        .sclk      (sclk_w[1]),
        .ss_n      (ss_w[1]),
        .mosi      (mosi_w[1]),
        .tx_finish (fin_w[1])
    );

    // Slave model: counts sclk edges while ss_n is low, samples on the CPHA edge.
    logic       sclk_p [2];
    logic       ss_p   [2] = '{1'b1, 1'b1};
    logic       mosi_p [2];
    logic [7:0] rxm    [2];
    logic [7:0] cap    [2];
    int edges [2];
    int edges_last [2];
    int lowc [2];
    int low_last [2];
    int highc [2];
    int gap_last [2];
    int stab [2];
    int fin_cnt [2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!ss_w[m]) begin
                if (ss_p[m]) begin
                    gap_last[m] <= highc[m];
                    edges[m]    <= 0;
                    rxm[m]      <= 8'h00;
                    lowc[m]     <= 1;
                    stab[m]     <= 0;
                end else begin
                    lowc[m] <= lowc[m] + 1;
                    if (sclk_w[m] != sclk_p[m]) begin
                        edges[m] <= edges[m] + 1;
                        if (edges[m][0] == CPHA_M[m]) begin
                            rxm[m] <= {mosi_p[m], rxm[m][7:1]};
                            if (mosi_w[m] != mosi_p[m]) stab[m] <= stab[m] + 1;
                        end
                    end
                end
            end else begin
                if (!ss_p[m]) begin
                    cap[m]        <= rxm[m];
                    low_last[m]   <= lowc[m];
                    edges_last[m] <= edges[m];
                    highc[m]      <= 1;
                end else begin
                    highc[m] <= highc[m] + 1;
                end
            end
            if (fin_w[m]) fin_cnt[m] <= fin_cnt[m] + 1;
            sclk_p[m] <= sclk_w[m];
            ss_p[m]   <= ss_w[m];
            mosi_p[m] <= mosi_w[m];
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_word;
        int         exp_lat;
        int         exp_low;
        int         exp_edges;
    } vec_t;

    vec_t vt [6];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fin(output int lat);
        lat = 1;
        while (!fin_w[0] && lat < 300) begin
            nclk();
            lat++;
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        int lat;
        int f0;
        f0 = fin_cnt[0];
        nclk();
        start  = 1'b1;
        data_i = v.data;
        nclk();
        start  = 1'b0;
        data_i = ~v.data;
        chk({tag, " ss_n fall"}, {31'b0, ss_w[0]}, 0);
        chk({tag, " busy"}, {31'b0, busy_w[1]}, 1);
        wait_fin(lat);
        chk({tag, " finish latency"}, lat, v.exp_lat);
        chk({tag, " finish mode3"}, {31'b0, fin_w[1]}, 1);
        chk({tag, " ss_n in FINISH"}, {31'b0, ss_w[0]}, 1);
        chk({tag, " busy in FINISH"}, {31'b0, busy_w[0]}, 1);
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        chk({tag, " rx_data m0"}, {24'b0, rx_w[0]}, {24'b0, v.exp_word});
        chk({tag, " rx_data m3"}, {24'b0, rx_w[1]}, {24'b0, v.exp_word});
`endif
        nclk();
        chk({tag, " finish drop"}, {31'b0, fin_w[0]}, 0);
        chk({tag, " busy drop"}, {31'b0, busy_w[1]}, 0);
        chk({tag, " word m0"}, {24'b0, cap[0]}, {24'b0, v.exp_word});
        chk({tag, " word m3"}, {24'b0, cap[1]}, {24'b0, v.exp_word});
        chk({tag, " ss_n low m3"}, low_last[1], v.exp_low);
        chk({tag, " edges m0"}, edges_last[0], v.exp_edges);
        chk({tag, " mosi stable"}, stab[0] + stab[1], 0);
        chk({tag, " finish count"}, fin_cnt[0] - f0, 1);
    endtask

    initial begin
        int lat;
        int f0;
        int k;
        vt[0] = '{8'hA5, 8'hA5, 73, 72, 16};
        vt[1] = '{8'h3C, 8'h3C, 73, 72, 16};
        vt[2] = '{8'h00, 8'h00, 73, 72, 16};
        vt[3] = '{8'hFF, 8'hFF, 73, 72, 16};
        vt[4] = '{8'h01, 8'h01, 73, 72, 16};
        vt[5] = '{8'h80, 8'h80, 73, 72, 16};

        repeat (3) nclk();
        chk("reset sclk m0", {31'b0, sclk_w[0]}, 0);
        chk("reset sclk m3", {31'b0, sclk_w[1]}, 1);
        chk("reset ss_n", {31'b0, ss_w[0]}, 1);
        chk("reset mosi", {31'b0, mosi_w[0]}, 0);
        chk("reset busy", {31'b0, busy_w[0]}, 0);
        chk("reset finish", {31'b0, fin_w[1]}, 0);
        rst_n = 1'b1;
        repeat (2) nclk();

        for (int i = 0; i < 6; i++) begin
            check_frame($sformatf("vec%0d", i), vt[i]);
        end

        // Start pulsed again mid-frame must be ignored.
        f0 = fin_cnt[0];
        nclk();
        start  = 1'b1;
        data_i = 8'h5A;
        nclk();
        start  = 1'b0;
        repeat (19) nclk();
        start  = 1'b1;
        data_i = 8'hFF;
        nclk();
        start  = 1'b0;
        wait_fin(lat);
        repeat (80) nclk();
        chk("ignored start word m0", {24'b0, cap[0]}, 32'h5A);
        chk("ignored start word m3", {24'b0, cap[1]}, 32'h5A);
        chk("ignored start finishes", fin_cnt[0] - f0, 1);
        chk("ignored start idle", {31'b0, ss_w[0]}, 1);

        // Back-to-back frames with start held high.
        f0 = fin_cnt[0];
        nclk();
        start  = 1'b1;
        data_i = 8'h01;
        nclk();
        data_i = 8'h80;
        wait_fin(lat);
        chk("b2b first latency", lat, 73);
        nclk();
        start  = 1'b0;
        data_i = 8'h00;
        chk("b2b second ss_n low", {31'b0, ss_w[0]}, 0);
        chk("b2b gap m0", gap_last[0], 1);
        chk("b2b gap m3", gap_last[1], 1);
        chk("b2b first word", {24'b0, cap[0]}, 32'h01);
        wait_fin(lat);
        chk("b2b second latency", lat, 73);
        nclk();
        chk("b2b second word m0", {24'b0, cap[0]}, 32'h80);
        chk("b2b second word m3", {24'b0, cap[1]}, 32'h80);
        chk("b2b finish count", fin_cnt[0] - f0, 2);

        // Reset mid-XFER after five sclk edges.
        nclk();
        start  = 1'b1;
        data_i = 8'hA5;
        nclk();
        start  = 1'b0;
        k = 0;
        while (edges[0] != 5 && k < 200) begin
            nclk();
            k++;
        end
        chk("reached edge 5", edges[0], 5);
        f0 = fin_cnt[0];
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort sclk m0", {31'b0, sclk_w[0]}, 0);
        chk("abort sclk m3", {31'b0, sclk_w[1]}, 1);
        chk("abort ss_n", {31'b0, ss_w[1]}, 1);
        chk("abort busy", {31'b0, busy_w[0]}, 0);
        chk("abort mosi", {31'b0, mosi_w[0]}, 0);
        repeat (3) nclk();
        rst_n = 1'b1;
        repeat (2) nclk();
        chk("abort no finish", fin_cnt[0] - f0, 0);

        check_frame("post reset", '{8'h96, 8'h96, 73, 72, 16});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1);
    end

endmodule
